// File: rtl/wakeup_ctrl_pkg.sv
// rtl/wakeup_ctrl_pkg.sv - register map, CTRL bit indices and timer state type for wakeup_ctrl
package wakeup_ctrl_pkg;

    localparam logic [4:0] REG_MASK      = 5'd0;
    localparam logic [4:0] REG_PENDING   = 5'd1;
    localparam logic [4:0] REG_CTRL      = 5'd2;
    localparam logic [4:0] REG_TIMER_CMP = 5'd3;
    localparam logic [4:0] REG_TIMER_VAL = 5'd4;

    localparam int CTRL_TIMER_EN   = 0;
    localparam int CTRL_PERIODIC   = 1;
    localparam int CTRL_SLEEP_ONLY = 2;

    localparam int TIMER_PEND_BIT = 31;

    typedef enum logic [1:0] {IDLE, COUNT, FIRE} timer_state_t;

    // Implemented MASK/PENDING bits: the event lines plus the timer bit.
    function automatic logic [31:0] valid_bits(input int num_events);
        return ((32'd1 << num_events) - 32'd1) | (32'd1 << TIMER_PEND_BIT);
    endfunction

endpackage

// File: rtl/wakeup_ctrl_if.sv
// rtl/wakeup_ctrl_if.sv - APB register bus bundle for wakeup_ctrl
interface wakeup_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/wakeup_timer.sv
// rtl/wakeup_timer.sv - one-shot/periodic wakeup timer FSM with 32-bit equality compare
module wakeup_timer
    import wakeup_ctrl_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        enable_i,
    input  logic        periodic_i,
    input  logic        sleep_only_i,
    input  logic        core_sleeping_i,
    input  logic [31:0] cmp_i,
    input  logic        restart_i,
    output logic        fire_o,
    output logic        clr_en_o,
    output logic [31:0] value_o
);

    timer_state_t state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         count_en;

    assign count_en = !sleep_only_i || core_sleeping_i;
    assign value_o  = cnt_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fire_o   = 1'b0;
        clr_en_o = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable_i) state_d = COUNT;
            end
            COUNT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (restart_i) begin
                    cnt_d = '0;
                end else if (count_en) begin
                    // Equality from zero: CMP+1 counted cycles per expiry.
                    if (cnt_q == cmp_i) begin
                        state_d = FIRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            FIRE: begin
                fire_o = 1'b1;
                cnt_d  = '0;
                if (periodic_i && enable_i) begin
                    state_d = COUNT;
                end else begin
                    state_d  = IDLE;
                    clr_en_o = !periodic_i;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/wakeup_ctrl.sv
// rtl/wakeup_ctrl.sv - APB wakeup scheduler: event edge latching, mask, timer, wakeup level
module wakeup_ctrl
    import wakeup_ctrl_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_EVENTS     = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    wakeup_ctrl_if.slave          apb,
    input  logic [NUM_EVENTS-1:0] event_lines_i,
    input  logic                  core_sleeping_i,
    output logic                  wakeup_event_o,
    output logic                  timer_irq_o
);

    localparam logic [31:0] VALID = valid_bits(NUM_EVENTS);

    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [4:0]                reg_idx;
    logic                      wr_en, rd_en;
    logic                      unused_paddr;

    logic [31:0]           mask_q, mask_d;
    logic [31:0]           pending_q, pending_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [31:0]           cmp_q, cmp_d;
    logic [NUM_EVENTS-1:0] prev_q, rise;
    logic                  armed_q;
    logic                  wake_q, irq_q;

    logic [31:0] w1c, set_bits;
    logic        fire, clr_en, restart;
    logic [31:0] timer_val;

    assign paddr        = apb.PADDR;
    assign reg_idx      = paddr[6:2];
    assign unused_paddr = ^{paddr[APB_ADDR_WIDTH-1:7], paddr[1:0]};
    assign wr_en        = apb.PSEL && apb.PENABLE && apb.PWRITE;
    assign rd_en        = apb.PSEL && apb.PENABLE && !apb.PWRITE;
    assign apb.PREADY   = 1'b1;
    assign apb.PSLVERR  = 1'b0;

    // armed_q suppresses the first cycle so lines high at reset release do not count as edges.
    assign rise     = armed_q ? (event_lines_i & ~prev_q) : '0;
    assign set_bits = {{(32 - NUM_EVENTS){1'b0}}, rise} | ({31'b0, fire} << TIMER_PEND_BIT);
    assign w1c      = (wr_en && reg_idx == REG_PENDING) ? apb.PWDATA : 32'd0;
    assign restart  = wr_en && ((reg_idx == REG_TIMER_CMP) ||
                                (reg_idx == REG_CTRL && apb.PWDATA[CTRL_TIMER_EN]));

    always_comb begin
        pending_d = ((pending_q & ~w1c) | set_bits) & VALID;
        mask_d    = mask_q;
        ctrl_d    = ctrl_q;
        cmp_d     = cmp_q;
        if (clr_en) ctrl_d[CTRL_TIMER_EN] = 1'b0;
        if (wr_en) begin
            case (reg_idx)
                REG_MASK:      mask_d = apb.PWDATA & VALID;
                REG_CTRL:      ctrl_d = apb.PWDATA[2:0];
                REG_TIMER_CMP: cmp_d  = apb.PWDATA;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mask_q    <= '0;
            pending_q <= '0;
            ctrl_q    <= '0;
            cmp_q     <= '0;
            prev_q    <= '0;
            armed_q   <= 1'b0;
            wake_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            pending_q <= pending_d;
            ctrl_q    <= ctrl_d;
            cmp_q     <= cmp_d;
            prev_q    <= event_lines_i;
            armed_q   <= 1'b1;
            wake_q    <= |(pending_d & mask_d);
            irq_q     <= fire;
        end
    end

    assign wakeup_event_o = wake_q;
    assign timer_irq_o    = irq_q;

    always_comb begin
        apb.PRDATA = 32'd0;
        if (rd_en) begin
            case (reg_idx)
                REG_MASK:      apb.PRDATA = mask_q;
                REG_PENDING:   apb.PRDATA = pending_q;
                REG_CTRL:      apb.PRDATA = {29'd0, ctrl_q};
                REG_TIMER_CMP: apb.PRDATA = cmp_q;
                REG_TIMER_VAL: apb.PRDATA = timer_val;
                default:       apb.PRDATA = 32'd0;
            endcase
        end
    end

    wakeup_timer u_timer (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .enable_i        (ctrl_q[CTRL_TIMER_EN]),
        .periodic_i      (ctrl_q[CTRL_PERIODIC]),
        .sleep_only_i    (ctrl_q[CTRL_SLEEP_ONLY]),
        .core_sleeping_i (core_sleeping_i),
        .cmp_i           (cmp_q),
        .restart_i       (restart),
        .fire_o          (fire),
        .clr_en_o        (clr_en),
        .value_o         (timer_val)
    );

endmodule
